// File: rtl/weight_feeder.sv
// rtl/weight_feeder.sv - weight tile loader for the top row of the systolic array
//
// Purpose: reads one weight row per cycle from the weight buffer (last row
// first, row 0 last) and shifts it into the top PE row with wwrite, then waits
// for wwrite to ripple down the array before pulsing done.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start, base_addr tile request and buffer address of tile row 0 (IDLE only)
//   num_rows         rows actually read (only with WFEED_PARTIAL_TILE_EN)
//   busy, done       transfer in progress / one-cycle completion pulse
//   mem_rd_en        weight buffer read strobe
//   mem_addr         weight buffer read address
//   mem_rdata        read data, one cycle after mem_rd_en
//   win_bus          per-column weight to the top PE row
//   wwrite_bus       per-column weight write strobe (all bits equal)
//
// Optional feature macro: WFEED_PARTIAL_TILE_EN (partial tiles; missing rows
// are shifted in as zero weights without a buffer read).
module weight_feeder #(
  parameter int WIDTH      = 8,
  parameter int ARRAY_SIZE = 16,
  parameter int ADDR_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
`ifdef WFEED_PARTIAL_TILE_EN
  input  logic [$clog2(ARRAY_SIZE+1)-1:0] num_rows,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [WIDTH*ARRAY_SIZE-1:0]   mem_rdata,
  output logic [WIDTH*ARRAY_SIZE-1:0]   win_bus,
  output logic [ARRAY_SIZE-1:0]         wwrite_bus
);

  localparam int CW = $clog2(ARRAY_SIZE + 2);
  localparam int RW = $clog2(ARRAY_SIZE + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [ADDR_W-1:0]             base_q, base_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  // slot: a row is being shifted this pass (read or zero-filled)
  logic                          slot_q, slot_d;
  // stage-1 copies: data for these flags is on mem_rdata this cycle
  logic                          slot1_q, rd1_q;
  logic [WIDTH*ARRAY_SIZE-1:0]   win_q, win_d;
  logic [ARRAY_SIZE-1:0]         wwrite_q, wwrite_d;

  logic                          issue;
  logic [CW-1:0]                 next_k;
  logic [CW-1:0]                 row_idx;
  logic [ADDR_W-1:0]             cur_base;
  logic [RW-1:0]                 cur_rows;

`ifdef WFEED_PARTIAL_TILE_EN
  logic [RW-1:0]                 nrows_q, nrows_d;
  logic [RW-1:0]                 rows_clamped;
  assign rows_clamped = (32'(num_rows) > ARRAY_SIZE) ? RW'(ARRAY_SIZE) : num_rows;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    addr_d   = addr_q;
    issue    = 1'b0;
    next_k   = '0;
    cur_base = base_q;
`ifdef WFEED_PARTIAL_TILE_EN
    nrows_d  = nrows_q;
    cur_rows = nrows_q;
`else
    cur_rows = RW'(ARRAY_SIZE);
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          busy_d   = 1'b1;
          cnt_d    = '0;
          base_d   = base_addr;
          cur_base = base_addr;
`ifdef WFEED_PARTIAL_TILE_EN
          nrows_d  = rows_clamped;
          cur_rows = rows_clamped;
`endif
          issue    = 1'b1;
          next_k   = '0;
        end
      end
      FETCH: begin
        if (cnt_q == CW'(ARRAY_SIZE - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          issue  = 1'b1;
          next_k = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // ARRAY_SIZE+2 cycles: pipeline tail plus one cycle per PE row
        if (cnt_q == CW'(ARRAY_SIZE + 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so the row chosen here is the one presented
    // in the next cycle: row ARRAY_SIZE-1-k for fetch slot k.
    row_idx = CW'(ARRAY_SIZE - 1) - next_k;
    slot_d  = issue;
    rd_en_d = issue && (row_idx < CW'(cur_rows));
    if (rd_en_d) begin
      addr_d = cur_base + ADDR_W'(row_idx);
    end

    win_d    = rd1_q ? mem_rdata : '0;
    wwrite_d = slot1_q ? '1 : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      slot_q   <= 1'b0;
      slot1_q  <= 1'b0;
      rd1_q    <= 1'b0;
      win_q    <= '0;
      wwrite_q <= '0;
`ifdef WFEED_PARTIAL_TILE_EN
      nrows_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      slot_q   <= slot_d;
      slot1_q  <= slot_q;
      rd1_q    <= rd_en_q;
      win_q    <= win_d;
      wwrite_q <= wwrite_d;
`ifdef WFEED_PARTIAL_TILE_EN
      nrows_q  <= nrows_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign win_bus    = win_q;
  assign wwrite_bus = wwrite_q;

endmodule

// File: tb/tb_weight_feeder.sv
// tb/tb_weight_feeder.sv - self-checking bench for weight_feeder
module tb_weight_feeder;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 8;
  localparam int DW = W * N;
  localparam int MAXC = 80;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
`ifdef WFEED_PARTIAL_TILE_EN
  logic [2:0]    num_rows;
`endif
  logic          busy, done, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] win_bus;
  logic [N-1:0]  wwrite_bus;

  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            start;
    logic [AW-1:0] base;
    int            nrows;
    bit            e_rd;
    logic [AW-1:0] e_addr;
    bit            e_ww;
    logic [DW-1:0] e_win;
    bit            e_done;
    bit            e_busy;
  } vec_t;

  vec_t tbl [MAXC];

  weight_feeder #(.WIDTH(W), .ARRAY_SIZE(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (rst),
    .start      (start),
    .base_addr  (base_addr),
`ifdef WFEED_PARTIAL_TILE_EN
    .num_rows   (num_rows),
`endif
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .win_bus    (win_bus),
    .wwrite_bus (wwrite_bus)
  );

  always #5 clk = ~clk;

  // weight buffer: data valid the cycle after the read strobe
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string what, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", what, c, act, exp);
    end
  endtask

  task automatic clear_tbl();
    for (int c = 0; c < MAXC; c++) begin
      tbl[c].start = 0; tbl[c].base = '0; tbl[c].nrows = N;
    end
  endtask

  // Reference model: a start seen while idle opens a transfer whose first
  // FETCH cycle is f0; reads at f0+k for row N-1-k, wwrite two cycles later,
  // done at f0+2N+2, busy f0..done.
  task automatic build(input int ncyc);
    int busy_until;
    busy_until = -1;
    for (int c = 0; c < MAXC; c++) begin
      tbl[c].e_rd = 0; tbl[c].e_addr = '0; tbl[c].e_ww = 0;
      tbl[c].e_win = '0; tbl[c].e_done = 0; tbl[c].e_busy = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      if (tbl[c].start && c > busy_until) begin
        int f0, nr;
        logic [AW-1:0] a;
        f0 = c + 1;
`ifdef WFEED_PARTIAL_TILE_EN
        nr = (tbl[c].nrows > N) ? N : tbl[c].nrows;
`else
        nr = N;
`endif
        for (int k = 0; k < N; k++) begin
          int row;
          row = N - 1 - k;
          a = tbl[c].base + AW'(row);
          if (f0 + k + 2 < MAXC) begin
            tbl[f0 + k + 2].e_ww = 1;
            if (row < nr) begin
              tbl[f0 + k].e_rd   = 1;
              tbl[f0 + k].e_addr = a;
              tbl[f0 + k + 2].e_win = mem[a];
            end
          end
        end
        for (int t = f0; t <= f0 + 2*N + 2 && t < MAXC; t++) tbl[t].e_busy = 1;
        if (f0 + 2*N + 2 < MAXC) tbl[f0 + 2*N + 2].e_done = 1;
        busy_until = f0 + 2*N + 2;
      end
    end
  endtask

  task automatic run(input int ncyc, input string name);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      start     = tbl[c].start;
      base_addr = tbl[c].base;
`ifdef WFEED_PARTIAL_TILE_EN
      num_rows  = 3'(tbl[c].nrows);
`endif
      @(negedge clk);
      chk({name, " rd_en"}, c, DW'(mem_rd_en), DW'(tbl[c].e_rd));
      if (tbl[c].e_rd) chk({name, " addr"}, c, DW'(mem_addr), DW'(tbl[c].e_addr));
      chk({name, " wwrite"}, c, DW'(wwrite_bus), tbl[c].e_ww ? DW'({N{1'b1}}) : '0);
      chk({name, " win"}, c, win_bus, tbl[c].e_win);
      chk({name, " done"}, c, DW'(done), DW'(tbl[c].e_done));
      chk({name, " busy"}, c, DW'(busy), DW'(tbl[c].e_busy));
    end
    #1 start = 0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
  endtask

  initial begin
    rst = 1; start = 0; base_addr = '0;
`ifdef WFEED_PARTIAL_TILE_EN
    num_rows = 3'd4;
`endif
    fill_rand();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 0, DW'(busy), '0);
    chk("reset done", 0, DW'(done), '0);
    chk("reset rd_en", 0, DW'(mem_rd_en), '0);
    chk("reset addr", 0, DW'(mem_addr), '0);
    chk("reset win", 0, win_bus, '0);
    chk("reset wwrite", 0, DW'(wwrite_bus), '0);
    rst = 0;

    // basic tile: rows 0x10..0x13 hold bytes row+1
    for (int r = 0; r < N; r++) mem[8'h10 + r] = {N{8'(r + 1)}};
    clear_tbl(); tbl[1].start = 1; tbl[1].base = 8'h10;
    build(24); run(24, "basic");

    fill_rand();
    clear_tbl(); tbl[1].start = 1; tbl[1].base = 8'hFE;
    build(24); run(24, "wrap");

    // starts during FETCH, DRAIN and the done cycle are ignored; the one
    // right after done starts a back-to-back tile
    clear_tbl();
    tbl[1].start = 1;  tbl[1].base = 8'h40;
    tbl[3].start = 1;  tbl[3].base = 8'h80;
    tbl[7].start = 1;  tbl[7].base = 8'h90;
    tbl[12].start = 1; tbl[12].base = 8'hA0;
    tbl[13].start = 1; tbl[13].base = 8'h20;
    build(30); run(30, "ignore_b2b");

`ifdef WFEED_PARTIAL_TILE_EN
    clear_tbl(); tbl[1].start = 1; tbl[1].base = 8'h30; tbl[1].nrows = 2;
    build(24); run(24, "partial2");
    clear_tbl(); tbl[1].start = 1; tbl[1].base = 8'h30; tbl[1].nrows = 0;
    build(24); run(24, "partial0");
    clear_tbl(); tbl[1].start = 1; tbl[1].base = 8'h30; tbl[1].nrows = 7;
    build(24); run(24, "clamp");
`endif

    for (int it = 0; it < 6; it++) begin
      fill_rand();
      clear_tbl();
      for (int c = 0; c < 40; c++) begin
        tbl[c].start = ($urandom_range(5) == 0);
        tbl[c].base  = AW'($urandom);
        tbl[c].nrows = $urandom_range(7);
      end
      build(60); run(60, "random");
    end

    // reset on the second wwrite cycle aborts the transfer
    @(posedge clk); #1 start = 1; base_addr = 8'h10;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre-abort wwrite", 0, DW'(wwrite_bus), DW'({N{1'b1}}));
    rst = 1;
    #1;
    chk("abort busy", 0, DW'(busy), '0);
    chk("abort rd_en", 0, DW'(mem_rd_en), '0);
    chk("abort addr", 0, DW'(mem_addr), '0);
    chk("abort win", 0, win_bus, '0);
    chk("abort wwrite", 0, DW'(wwrite_bus), '0);
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 3*N; c++) begin
      @(negedge clk);
      chk("post-abort done", c, DW'(done), '0);
      chk("post-abort busy", c, DW'(busy), '0);
    end
    for (int r = 0; r < N; r++) mem[8'h10 + r] = {N{8'(r + 1)}};
    clear_tbl(); tbl[1].start = 1; tbl[1].base = 8'h10;
    build(24); run(24, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
